// File: rtl/ether_rx.sv
// RMII receive front end: finds preamble + SFD, strips them and streams the frame body as dibits.
// Latency: 1 cycle from rxd sample to axiod. No backpressure: the PHY cannot be stalled, so the consumer must keep up.
module ether_rx #(
  parameter int PREAMBLE_MIN = 24,
  parameter int MAX_DIBITS   = 6072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       err
);

  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam int LW = $clog2(MAX_DIBITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          axiov_q, axiov_d;
  logic [1:0]    axiod_q, axiod_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      len_q   <= '0;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      len_q   <= len_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    len_d   = len_q;
    axiov_d = 1'b0;
    axiod_d = axiod_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (crsdv) begin
          case (rxd)
            2'b01: begin
              state_d = PREAMBLE;
              pcnt_d  = PW'(1);
            end
            2'b10, 2'b11: begin
              state_d = DROP;
              err_d   = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      PREAMBLE: begin
        if (!crsdv) begin
          // Carrier lost during preamble is just noise, not a violation.
          state_d = IDLE;
          pcnt_d  = '0;
        end else if (rxd == 2'b01) begin
          if (pcnt_q < PW'(PREAMBLE_MIN)) begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end else if (rxd == 2'b11 && pcnt_q >= PW'(PREAMBLE_MIN)) begin
          state_d = DATA;
          pcnt_d  = '0;
          len_d   = '0;
        end else begin
          state_d = DROP;
          pcnt_d  = '0;
          err_d   = 1'b1;
        end
      end

      DATA: begin
        if (!crsdv) begin
          state_d = IDLE;
          len_d   = '0;
        end else if (len_q < LW'(MAX_DIBITS)) begin
          axiov_d = 1'b1;
          axiod_d = rxd;
          len_d   = len_q + LW'(1);
        end else begin
          state_d = DROP;
          len_d   = '0;
          err_d   = 1'b1;
        end
      end

      DROP: begin
        if (!crsdv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ether_rx.sv
// Directed bench for ether_rx: default-size instance plus a MAX_DIBITS=8 instance for truncation.
module tb_ether_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       axiov0, err0, axiov1, err1;
  logic [1:0] axiod0, axiod1;

  int n_cmp = 0;
  int n_bad = 0;
  int step = 0;
  int sfd = 0;
  int bad = 0;

  int          ov[2];
  int          bursts[2];
  int          err_cnt[2];
  int          first_ov[2];
  int          last_ov[2];
  int          err_step[2];
  logic [63:0] cap[2];
  logic        prev[2];

  ether_rx dut0 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov0), .axiod(axiod0), .err(err0)
  );

  ether_rx #(.PREAMBLE_MIN(24), .MAX_DIBITS(8)) dut1 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov1), .axiod(axiod1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      ov[d] = 0; bursts[d] = 0; err_cnt[d] = 0;
      first_ov[d] = -1; last_ov[d] = -1; err_step[d] = -1;
      cap[d] = '0; prev[d] = 1'b0;
    end
  endtask

  task automatic tally(input int d, input logic v, input logic [1:0] dat, input logic e);
    logic [63:0] t;
    if (v) begin
      if (!prev[d]) bursts[d]++;
      if (first_ov[d] < 0) first_ov[d] = step;
      if (ov[d] < 32) begin
        t = cap[d];
        t[2*ov[d] +: 2] = dat;
        cap[d] = t;
      end
      ov[d]++;
      last_ov[d] = step;
    end
    if (e) begin
      err_cnt[d]++;
      err_step[d] = step;
    end
    prev[d] = v;
  endtask

  // One RMII cycle: apply inputs, let the edge sample them, then observe registered outputs.
  task automatic drive(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
    step++;
    tally(0, axiov0, axiod0, err0);
    tally(1, axiov1, axiod1, err1);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 2'b01);
  endtask

  task automatic body(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 2'(i % 4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  initial begin
    clear_stats();

    // Reset holds everything low even with an illegal dibit present
    rst = 1'b0;
    drive(1'b1, 2'b11);
    drive(1'b1, 2'b11);
    check("rst_axiov", axiov0, 0);
    check("rst_axiod", axiod0, 0);
    check("rst_err", err0, 0);
    check("rst_axiov_small", axiov1, 0);
    rst = 1'b1;
    idle(2);

    // 1: nominal frame
    clear_stats();
    preamble(31);
    drive(1'b1, 2'b11);
    sfd = step;
    body(16);
    drive(1'b0, 2'b00);
    check("t1_axiov_falls", axiov0, 0);
    idle(2);
    check("t1_len", ov[0], 16);
    check("t1_first", first_ov[0], sfd + 1);
    check("t1_last", last_ov[0], sfd + 16);
    check("t1_bursts", bursts[0], 1);
    check("t1_data", cap[0][31:0], 64'hE4E4E4E4);
    check("t1_err", err_cnt[0], 0);

    // 2: short preamble, then boundary lengths 23 (reject) and 24 (accept)
    clear_stats();
    preamble(10);
    drive(1'b1, 2'b11);
    sfd = step;
    body(8);
    idle(2);
    check("t2_err_cnt", err_cnt[0], 1);
    check("t2_err_step", err_step[0], sfd);
    check("t2_axiov", ov[0], 0);

    clear_stats();
    preamble(23);
    drive(1'b1, 2'b11);
    body(8);
    idle(2);
    check("t2_p23_err", err_cnt[0], 1);
    check("t2_p23_axiov", ov[0], 0);

    clear_stats();
    preamble(24);
    drive(1'b1, 2'b11);
    body(8);
    idle(2);
    check("t2_p24_len", ov[0], 8);
    check("t2_p24_data", cap[0][15:0], 64'hE4E4);
    check("t2_p24_err", err_cnt[0], 0);

    // 3: bad dibit inside preamble
    clear_stats();
    preamble(20);
    drive(1'b1, 2'b10);
    bad = step;
    preamble(15);
    drive(1'b1, 2'b11);
    body(8);
    idle(2);
    check("t3_err_cnt", err_cnt[0], 1);
    check("t3_err_step", err_step[0], bad);
    check("t3_axiov", ov[0], 0);

    // 4: oversize on the small instance; the large one passes all 12
    clear_stats();
    preamble(24);
    drive(1'b1, 2'b11);
    sfd = step;
    body(12);
    idle(2);
    check("t4_len", ov[1], 8);
    check("t4_last", last_ov[1], sfd + 8);
    check("t4_err_cnt", err_cnt[1], 1);
    check("t4_err_step", err_step[1], sfd + 9);
    check("t4_data", cap[1][15:0], 64'hE4E4);
    check("t4_big_len", ov[0], 12);
    check("t4_big_err", err_cnt[0], 0);

    // 5: reset during body dibit 5
    clear_stats();
    preamble(24);
    drive(1'b1, 2'b11);
    body(5);
    check("t5_pre_len", ov[0], 5);
    rst = 1'b0;
    drive(1'b1, 2'b01);
    check("t5_rst_axiov", axiov0, 0);
    check("t5_rst_err", err0, 0);
    rst = 1'b1;
    for (int i = 6; i < 16; i++) drive(1'b1, 2'(i % 4));
    idle(1);
    check("t5_post_len", ov[0], 5);
    clear_stats();
    preamble(24);
    drive(1'b1, 2'b11);
    body(4);
    idle(2);
    check("t5_recover_len", ov[0], 4);
    check("t5_recover_err", err_cnt[0], 0);

    // 6: back-to-back frames with a single idle cycle
    clear_stats();
    preamble(31);
    drive(1'b1, 2'b11);
    body(8);
    idle(1);
    preamble(31);
    drive(1'b1, 2'b11);
    body(8);
    idle(2);
    check("t6_bursts", bursts[0], 2);
    check("t6_len", ov[0], 16);
    check("t6_data", cap[0][31:0], 64'hE4E4E4E4);
    check("t6_err", err_cnt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
Name: ether_rx

Overview:
- RMII receive front end. Consumes raw crsdv/rxd from the PHY at one dibit per clk cycle (50 MHz, 100 Mb/s).
- Detects the preamble and SFD, strips both, and emits the frame body (destination MAC through FCS) as an AXI-style dibit stream, in wire bit order.
- Sits directly upstream of the Ethernet checksum stage, which consumes axiov/axiod unmodified.

Parameters:
- PREAMBLE_MIN, 24: minimum count of consecutive 2'b01 dibits before the SFD-terminating 2'b11 for the frame to be accepted.
- MAX_DIBITS, 6072: maximum body length in dibits (1518 bytes × 4). Longer frames are truncated and dropped.

Ports:
- clk  input  1  system clock, RMII reference clock domain.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- crsdv  input  1  RMII carrier sense / data valid.
- rxd  input  2  RMII receive dibit.
- axiov  output  1  body dibit valid.
- axiod  output  2  body dibit, equal to rxd as sampled one cycle earlier.
- err  output  1  one-cycle pulse on preamble/SFD violation or oversize frame.

Behaviour:
- General rules:
  - All outputs are registered.
  - Reset is sampled on clk. While rst==0: state=IDLE, axiov=0, axiod=2'b00, err=0, all counters cleared.
  - Reset asserted mid-frame aborts the frame. axiov falls the cycle after rst is sampled low.
- Counters:
  - pcnt counts preamble dibits and saturates at PREAMBLE_MIN.
  - len counts emitted body dibits, width $clog2(MAX_DIBITS+1).
- States, evaluated per cycle on the sampled crsdv/rxd:
  - IDLE:
    - crsdv==0, or rxd==00: stay.
    - rxd==01: go to PREAMBLE, pcnt=1.
    - rxd==10 or 11: go to DROP, err=1.
  - PREAMBLE:
    - crsdv==0: go to IDLE, no err.
    - rxd==01: pcnt++ (saturating).
    - rxd==11 and pcnt>=PREAMBLE_MIN: go to DATA, len=0.
    - rxd==11 and pcnt<PREAMBLE_MIN: go to DROP, err=1.
    - rxd==00 or 10: go to DROP, err=1.
  - DATA:
    - crsdv==1 and len<MAX_DIBITS: axiov=1, axiod=rxd, len++.
    - crsdv==1 and len==MAX_DIBITS: axiov=0, err=1, go to DROP.
    - crsdv==0: axiov=0, go to IDLE.
  - DROP:
    - axiov=0 throughout.
    - crsdv==0: go to IDLE.
- Latency: exactly 1 cycle from the rxd sample to axiod. The first body dibit appears the cycle after the first data dibit is sampled, i.e. 2 cycles after the SFD 2'b11 is sampled.
- axiov is contiguous for the whole body; no bubbles inside a frame.
- axiov deasserts the cycle after crsdv is sampled low, so downstream sees a clean end of frame.
- Back-to-back frames: one cycle of crsdv==0 is sufficient to return to IDLE and accept the next preamble.
- err is high for exactly one cycle per event and is 0 otherwise.
- axiod holds its last value when axiov==0. Consumers must ignore it then.
- The SFD dibit 2'b11 is never emitted.
- No FCS checking here; that is done downstream.

Test Plan:
1. Nominal frame: crsdv=1, 31× rxd=01, then 11, then 16 body dibits (0,1,2,3 repeating), then crsdv=0 → axiov high for exactly 16 cycles, starting 2 cycles after the 11 is sampled; axiod replays 0,1,2,3 in order; err never pulses.
2. Short preamble: 10× 01 then 11, then body dibits → err pulses once, axiov stays 0 for the whole frame, next well-formed frame is accepted.
3. Bad dibit: 20× 01, then 10, then 15× 01, then 11, then body → err pulses once, frame dropped until crsdv falls, axiov stays 0.
4. Oversize: run with MAX_DIBITS=8 and a 12-dibit body → axiov high for 8 cycles, err pulses once in the cycle axiov falls, remaining 4 dibits suppressed.
5. Reset mid-frame: drive rst=0 during body dibit 5 → axiov=0 and err=0 on the next cycle; after reset release with crsdv still high in DATA-like traffic, no output until a fresh preamble is seen.
6. Back-to-back: two nominal 8-dibit frames separated by one crsdv=0 cycle → two axiov bursts of 8 cycles each, separated by a gap of at least 1 cycle; no err.
